usb_tx_encoder: RTL and testbench

Bit-level USB full-speed transmit encoder. Consumes the serial data stream from the transmit parallel-to-serial shift register, paces it at one bit per `CLKS_PER_BIT` clocks, applies bit stuffing and NRZI encoding, and drives the D+/D- line pair including EOP. It sits directly downstream of the TX shift register and generates that register's `shift_enable`; the TX packet controller upstream handles byte loads.

---
 rtl/usb_tx_pkg.sv | 24 ++
 rtl/usb_tx_bit_timer.sv | 28 ++
 rtl/usb_tx_encoder.sv | 141 ++++++++++++++
 tb/tb_usb_tx_encoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    // Line symbols as {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int CLKS_PER_BIT_DEF = 8;
    localparam logic [2:0] ONES_MAX = 3'd6;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the last clock.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;

    assign bit_end = (count_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || bit_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed TX bit encoder: paces the serial stream, bit-stuffs, NRZI-encodes
// and drives D+/D- including EOP. Generates shift_enable for the upstream shift register.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_start,
    input  logic tx_last,
    input  logic serial_in,
    output logic shift_enable,
    output logic byte_done,
    output logic dplus_out,
    output logic dminus_out,
    output logic tx_busy,
    output logic tx_done
);

    state_t     state_q, state_nxt;
    logic [1:0] line_q, line_nxt;
    logic [2:0] ones_q, ones_nxt, ones_base;
    logic [2:0] bit_cnt_q, bit_cnt_nxt;
    logic       eop_q, eop_nxt;
    logic       se0_half_q, se0_half_nxt;
    logic       tx_done_nxt;
    logic       take_data;
    logic       bit_end;

    // Timer is parked at 0 while idle so tx_start always begins a fresh period
    usb_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == ST_IDLE),
        .bit_end(bit_end)
    );

    assign shift_enable = take_data;
    assign byte_done    = take_data && (bit_cnt_q == 3'd7);
    assign dplus_out    = line_q[1];
    assign dminus_out   = line_q[0];
    assign tx_busy      = (state_q != ST_IDLE);
    assign ones_base    = (state_q == ST_IDLE) ? 3'd0 : ones_q;

    always_comb begin
        state_nxt    = state_q;
        line_nxt     = line_q;
        ones_nxt     = ones_q;
        bit_cnt_nxt  = bit_cnt_q;
        eop_nxt      = eop_q;
        se0_half_nxt = se0_half_q;
        tx_done_nxt  = 1'b0;
        take_data    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) take_data = 1'b1;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (ones_q == ONES_MAX) begin
                        state_nxt = ST_STUFF;
                        line_nxt  = nrzi_toggle(line_q);
                        ones_nxt  = 3'd0;
                    end else if (eop_q) begin
                        state_nxt    = ST_EOP_SE0;
                        line_nxt     = LINE_SE0;
                        se0_half_nxt = 1'b0;
                    end else begin
                        take_data = 1'b1;
                    end
                end
            end
            ST_STUFF: begin
                if (bit_end) begin
                    if (eop_q) begin
                        state_nxt    = ST_EOP_SE0;
                        line_nxt     = LINE_SE0;
                        se0_half_nxt = 1'b0;
                    end else begin
                        take_data = 1'b1;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    if (se0_half_q) begin
                        state_nxt = ST_EOP_J;
                        line_nxt  = LINE_J;
                    end else begin
                        se0_half_nxt = 1'b1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    state_nxt   = ST_IDLE;
                    eop_nxt     = 1'b0;
                    tx_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                line_nxt  = LINE_J;
            end
        endcase

        // A data bit: 0 toggles the line, 1 holds it and extends the run of ones
        if (take_data) begin
            state_nxt   = ST_DATA;
            line_nxt    = serial_in ? line_q : nrzi_toggle(line_q);
            ones_nxt    = serial_in ? (ones_base + 3'd1) : 3'd0;
            bit_cnt_nxt = bit_cnt_q + 3'd1;
            if ((bit_cnt_q == 3'd7) && tx_last) eop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            line_q     <= LINE_J;
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            eop_q      <= 1'b0;
            se0_half_q <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            line_q     <= line_nxt;
            ones_q     <= ones_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            eop_q      <= eop_nxt;
            se0_half_q <= se0_half_nxt;
            tx_done    <= tx_done_nxt;
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder with a behavioural upstream shift register.
module tb_usb_tx_encoder;

    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] Z = 2'b00;

    logic clk = 1'b0;
    logic rst, tx_start, tx_last, serial_in;
    logic shift_enable, byte_done, dplus_out, dminus_out, tx_busy, tx_done;

    logic       ld;
    logic [7:0] ld_data;
    logic [7:0] next_byte;
    logic [7:0] sr = 8'h00;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_last     (tx_last),
        .serial_in   (serial_in),
        .shift_enable(shift_enable),
        .byte_done   (byte_done),
        .dplus_out   (dplus_out),
        .dminus_out  (dminus_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    // Upstream TX shift register, LSB first; a load wins over a shift
    assign serial_in = sr[0];
    always @(posedge clk) begin
        if (ld)                sr <= ld_data;
        else if (byte_done)    sr <= next_byte;
        else if (shift_enable) sr <= {1'b0, sr[7:1]};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit period: line holds sym for 8 clocks; strobes only in its last clock
    task automatic period(input string tag, input logic [1:0] sym, input logic se, input logic bd);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("%s.line[%0d]", tag, i), {6'd0, dplus_out, dminus_out}, {6'd0, sym});
            chk($sformatf("%s.se[%0d]", tag, i), {7'd0, shift_enable}, {7'd0, (i == 7) ? se : 1'b0});
            chk($sformatf("%s.bd[%0d]", tag, i), {7'd0, byte_done}, {7'd0, (i == 7) ? bd : 1'b0});
            chk($sformatf("%s.busy[%0d]", tag, i), {7'd0, tx_busy}, 8'd1);
        end
    endtask

    task automatic start_pkt(input string tag, input logic [7:0] first);
        @(negedge clk);
        ld = 1'b1;
        ld_data = first;
        @(posedge clk);
        #1 ld = 1'b0;
        @(negedge clk);
        tx_start = 1'b1;
        #1;
        chk({tag, ".start_se"}, {7'd0, shift_enable}, 8'd1);
        chk({tag, ".start_bd"}, {7'd0, byte_done}, 8'd0);
        chk({tag, ".start_busy"}, {7'd0, tx_busy}, 8'd0);
        @(posedge clk);
        #1 tx_start = 1'b0;
        chk({tag, ".busy_rise"}, {7'd0, tx_busy}, 8'd1);
    endtask

    // SYNC 0x80 sent LSB first: seven 0s then a 1
    task automatic send_sync(input string tag);
        start_pkt(tag, 8'h80);
        period({tag, ".s0"}, K, 1'b1, 1'b0);
        period({tag, ".s1"}, J, 1'b1, 1'b0);
        period({tag, ".s2"}, K, 1'b1, 1'b0);
        period({tag, ".s3"}, J, 1'b1, 1'b0);
        period({tag, ".s4"}, K, 1'b1, 1'b0);
        period({tag, ".s5"}, J, 1'b1, 1'b0);
        period({tag, ".s6"}, K, 1'b1, 1'b1);
        period({tag, ".s7"}, K, 1'b1, 1'b0);
    endtask

    task automatic eop(input string tag);
        period({tag, ".se0a"}, Z, 1'b0, 1'b0);
        period({tag, ".se0b"}, Z, 1'b0, 1'b0);
        period({tag, ".eopj"}, J, 1'b0, 1'b0);
        @(negedge clk);
        chk({tag, ".done"}, {7'd0, tx_done}, 8'd1);
        chk({tag, ".busy_fall"}, {7'd0, tx_busy}, 8'd0);
        chk({tag, ".idle_line"}, {6'd0, dplus_out, dminus_out}, {6'd0, J});
        @(negedge clk);
        chk({tag, ".done_pulse"}, {7'd0, tx_done}, 8'd0);
    endtask

    initial begin
        rst = 1'b0; tx_start = 1'b0; tx_last = 1'b0;
        ld = 1'b0; ld_data = 8'h00; next_byte = 8'h00;

        // Reset applied mid-cycle takes effect without a clock edge
        #3 rst = 1'b1;
        #1;
        chk("rst.line", {6'd0, dplus_out, dminus_out}, {6'd0, J});
        chk("rst.se", {7'd0, shift_enable}, 8'd0);
        chk("rst.bd", {7'd0, byte_done}, 8'd0);
        chk("rst.busy", {7'd0, tx_busy}, 8'd0);
        chk("rst.done", {7'd0, tx_done}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Packet A: SYNC, 0xFF (stuffed after six held Ks), final 0x00
        next_byte = 8'hFF;
        send_sync("A");
        next_byte = 8'h00;
        period("A.q0", K, 1'b1, 1'b0);
        period("A.q1", K, 1'b1, 1'b0);
        period("A.q2", K, 1'b1, 1'b0);
        period("A.q3", K, 1'b1, 1'b0);
        period("A.q4", K, 1'b0, 1'b0);
        period("A.stuff", J, 1'b1, 1'b0);
        period("A.q5", J, 1'b1, 1'b0);
        period("A.q6", J, 1'b1, 1'b1);
        period("A.q7", J, 1'b1, 1'b0);
        tx_last = 1'b1;
        period("A.r0", K, 1'b1, 1'b0);
        period("A.r1", J, 1'b1, 1'b0);
        period("A.r2", K, 1'b1, 1'b0);
        period("A.r3", J, 1'b1, 1'b0);
        period("A.r4", K, 1'b1, 1'b0);
        period("A.r5", J, 1'b1, 1'b0);
        period("A.r6", K, 1'b1, 1'b1);
        period("A.r7", J, 1'b0, 1'b0);
        eop("A");

        // Packet B: final byte 0xFC ends in six 1s; tx_start mid-packet is ignored
        tx_last = 1'b0;
        next_byte = 8'hFC;
        send_sync("B");
        tx_last = 1'b1;
        period("B.r0", J, 1'b1, 1'b0);
        period("B.r1", K, 1'b1, 1'b0);
        period("B.r2", K, 1'b1, 1'b0);
        tx_start = 1'b1;
        period("B.r3", K, 1'b1, 1'b0);
        tx_start = 1'b0;
        period("B.r4", K, 1'b1, 1'b0);
        period("B.r5", K, 1'b1, 1'b0);
        period("B.r6", K, 1'b1, 1'b1);
        period("B.r7", K, 1'b0, 1'b0);
        period("B.stuff", J, 1'b0, 1'b0);
        eop("B");

        // Packet C: reset in the middle of a run of ones
        tx_last = 1'b0;
        next_byte = 8'hFF;
        send_sync("C");
        period("C.q0", K, 1'b1, 1'b0);
        period("C.q1", K, 1'b1, 1'b0);
        period("C.q2", K, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("C.abort_line", {6'd0, dplus_out, dminus_out}, {6'd0, J});
        chk("C.abort_se", {7'd0, shift_enable}, 8'd0);
        chk("C.abort_bd", {7'd0, byte_done}, 8'd0);
        chk("C.abort_busy", {7'd0, tx_busy}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("C.quiet_se[%0d]", i), {7'd0, shift_enable}, 8'd0);
            chk($sformatf("C.quiet_line[%0d]", i), {6'd0, dplus_out, dminus_out}, {6'd0, J});
        end

        // Packet D: single final byte 0xFF; stuff after exactly six 1s proves a cleared ones count
        tx_last = 1'b1;
        start_pkt("D", 8'hFF);
        period("D.b0", J, 1'b1, 1'b0);
        period("D.b1", J, 1'b1, 1'b0);
        period("D.b2", J, 1'b1, 1'b0);
        period("D.b3", J, 1'b1, 1'b0);
        period("D.b4", J, 1'b1, 1'b0);
        period("D.b5", J, 1'b0, 1'b0);
        period("D.stuff", K, 1'b1, 1'b0);
        period("D.b6", K, 1'b1, 1'b1);
        period("D.b7", K, 1'b0, 1'b0);
        eop("D");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
